// File: rtl/decay_pkg.sv
// Shared definitions for the synaptic current decay bank: sweep state
// encoding and Q-format / saturation bound helpers.
package decay_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Largest positive value of a signed width-bit number: 2^(width-1)-1.
   function automatic longint max_pos(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // Most negative value of a signed width-bit number: -2^(width-1).
   function automatic longint min_neg(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

   // Q-format unity: 1.0 = 2^frac.
   function automatic longint q_one(input int frac);
      return 64'sd1 <<< frac;
   endfunction

endpackage

// File: rtl/fixed_mult_sat.sv
// Combinational signed fixed-point multiply: full-width product, arithmetic
// shift right by FRAC (floor toward minus infinity), saturate to WIDTH bits.
module fixed_mult_sat
   import decay_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int FRAC  = 8
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] y
);

   localparam int PW = 2 * WIDTH;
   localparam logic signed [PW-1:0] P_MAX = PW'(max_pos(WIDTH));
   localparam logic signed [PW-1:0] P_MIN = PW'(min_neg(WIDTH));

   logic signed [PW-1:0] a_x;
   logic signed [PW-1:0] b_x;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] shifted;

   assign a_x     = {{WIDTH{a[WIDTH-1]}}, a};
   assign b_x     = {{WIDTH{b[WIDTH-1]}}, b};
   assign prod    = a_x * b_x;
   assign shifted = prod >>> FRAC;

   // Clamp the rescaled product into the representable range.
   always_comb begin
      if (shifted > P_MAX) begin
         y = P_MAX[WIDTH-1:0];
      end else if (shifted < P_MIN) begin
         y = P_MIN[WIDTH-1:0];
      end else begin
         y = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/current_decay_bank.sv
// Bank of N_CH saturating synaptic-current registers. Injects accumulate at
// any time; a step strobe runs one sweep that scales every channel by the
// latched decay factor, one channel per cycle through a shared multiplier.
//
//   state | meaning
//   IDLE  | waiting for step; injects only
//   SWEEP | channel ch_idx is being decayed this cycle
//   DONE  | sweep finished; done is high for this one cycle
module current_decay_bank
   import decay_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int FRAC  = 8,
   parameter int N_CH  = 4,
   parameter int CH_W  = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    step,
   input  logic [WIDTH-1:0]        decay,
   input  logic                    inj_valid,
   input  logic [CH_W-1:0]         inj_ch,
   input  logic [WIDTH-1:0]        inj_val,
   output logic [N_CH*WIDTH-1:0]   curr_out,
   output logic                    busy,
   output logic                    done
);

   localparam logic signed [WIDTH-1:0] MAX_W   = WIDTH'(max_pos(WIDTH));
   localparam logic signed [WIDTH-1:0] MIN_W   = WIDTH'(min_neg(WIDTH));
   localparam logic [CH_W-1:0]         LAST_CH = CH_W'(N_CH - 1);

   state_t                    state;
   state_t                    state_nx;
   logic                      busy_d;
   logic                      done_d;
   logic [CH_W-1:0]           ch_idx;
   logic signed [WIDTH-1:0]   decay_q;
   logic signed [WIDTH-1:0]   curr    [N_CH];
   logic signed [WIDTH-1:0]   curr_nx [N_CH];
   logic signed [WIDTH-1:0]   mult_a;
   logic signed [WIDTH-1:0]   mult_y;

   function automatic logic signed [WIDTH-1:0] sat_add(
      input logic signed [WIDTH-1:0] x,
      input logic signed [WIDTH-1:0] v
   );
      logic signed [WIDTH:0] s;
      s = {x[WIDTH-1], x} + {v[WIDTH-1], v};
      if (s[WIDTH] != s[WIDTH-1]) begin
         return s[WIDTH] ? MIN_W : MAX_W;
      end
      return s[WIDTH-1:0];
   endfunction

   // State, busy and done registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   // Sweep sequencing; a step outside IDLE is simply dropped.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (step) state_nx = SWEEP;
         SWEEP:   if (ch_idx == LAST_CH) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Flags are decoded from the next state so they come straight off flops.
   always_comb begin
      busy_d = (state_nx == SWEEP);
      done_d = (state_nx == DONE);
   end

   // Select the channel currently being swept for the shared multiplier.
   always_comb begin
      mult_a = curr[0];
      for (int k = 1; k < N_CH; k++) begin
         if (ch_idx == CH_W'(k)) mult_a = curr[k];
      end
   end

   fixed_mult_sat #(
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
   ) u_mult (
      .a (mult_a),
      .b (decay_q),
      .y (mult_y)
   );

   // Per-channel update: the decayed value, if any, is the base an inject adds to.
   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         curr_nx[k] = curr[k];
         if (state == SWEEP && ch_idx == CH_W'(k)) curr_nx[k] = mult_y;
         if (inj_valid && inj_ch == CH_W'(k)) curr_nx[k] = sat_add(curr_nx[k], inj_val);
      end
   end

   // Channel registers, decay latch and sweep index.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) curr[k] <= '0;
         decay_q <= '0;
         ch_idx  <= '0;
      end else begin
         for (int k = 0; k < N_CH; k++) curr[k] <= curr_nx[k];
         if (state == IDLE && step) begin
            decay_q <= decay;
            ch_idx  <= '0;
         end else if (state == SWEEP && ch_idx != LAST_CH) begin
            ch_idx <= ch_idx + CH_W'(1);
         end
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_out
      assign curr_out[g*WIDTH +: WIDTH] = curr[g];
   end

endmodule

// File: tb/tb_current_decay_bank.sv
// Randomised and directed bench for current_decay_bank with a cycle-level
// arithmetic reference model and a done-triggered scoreboard.
module tb_current_decay_bank;

   localparam int     W    = 17;
   localparam int     N    = 4;
   localparam int     CW   = 2;
   localparam longint MAXP = 65535;
   localparam longint MINN = -65536;
   localparam longint ONE  = 256;

   logic            clk = 1'b0;
   logic            rst, step, inj_valid;
   logic [W-1:0]    decay, inj_val;
   logic [CW-1:0]   inj_ch;
   logic [N*W-1:0]  curr_out;
   logic            busy, done;

   logic            rst3, step3, iv3;
   logic [W-1:0]    decay3, ivl3;
   logic [1:0]      ic3;
   logic [3*W-1:0]  curr_out3;
   logic            busy3, done3;
   logic            u3_finished = 1'b0;

   always #5 clk = ~clk;

   current_decay_bank #(.WIDTH(W), .FRAC(8), .N_CH(N), .CH_W(CW)) dut (
      .clk (clk), .rst (rst), .step (step), .decay (decay),
      .inj_valid (inj_valid), .inj_ch (inj_ch), .inj_val (inj_val),
      .curr_out (curr_out), .busy (busy), .done (done)
   );

   current_decay_bank #(.WIDTH(W), .FRAC(8), .N_CH(3), .CH_W(2)) u3 (
      .clk (clk), .rst (rst3), .step (step3), .decay (decay3),
      .inj_valid (iv3), .inj_ch (ic3), .inj_val (ivl3),
      .curr_out (curr_out3), .busy (busy3), .done (done3)
   );

   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   longint m [N];
   longint dq;
   int     pos;
   int     t0;

   typedef struct {
      logic [N*W-1:0] vec;
      int             edge_no;
   } exp_t;
   exp_t sbq[$];

   function automatic longint sat(input longint x);
      if (x > MAXP) return MAXP;
      if (x < MINN) return MINN;
      return x;
   endfunction

   function automatic longint mulq(input longint a, input longint d);
      longint p, q;
      p = a * d;
      q = p / ONE;
      if (p < 0 && (p % ONE) != 0) q = q - 1;
      return sat(q);
   endfunction

   function automatic longint chv(input int k);
      logic signed [W-1:0] s;
      s = curr_out[k*W +: W];
      return longint'(s);
   endfunction

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_state();
      for (int k = 0; k < N; k++) check($sformatf("curr[%0d]", k), chv(k), m[k]);
      check("busy", longint'(busy), (pos >= 0 && pos < N) ? 1 : 0);
      check("done", longint'(done), (pos == N) ? 1 : 0);
   endtask

   // Reference: effect of the coming edge given the inputs for this cycle.
   task automatic model_edge(input logic s, input logic [W-1:0] d, input logic iv,
                             input logic [CW-1:0] ic, input logic [W-1:0] v, input logic r);
      exp_t e;
      logic signed [W-1:0] sv;
      if (r) begin
         for (int k = 0; k < N; k++) m[k] = 0;
         dq  = 0;
         pos = -1;
         return;
      end
      if (pos >= 0 && pos < N) m[pos] = mulq(m[pos], dq);
      if (iv && int'(ic) < N) begin
         sv = v;
         m[ic] = sat(m[ic] + longint'(sv));
      end
      if (pos == -1) begin
         if (s) begin
            sv  = d;
            dq  = longint'(sv);
            pos = 0;
            t0  = edge_cnt + 1;
         end
      end else if (pos < N - 1) begin
         pos++;
      end else if (pos == N - 1) begin
         pos = N;
         for (int k = 0; k < N; k++) e.vec[k*W +: W] = m[k][W-1:0];
         e.edge_no = t0 + N;
         sbq.push_back(e);
      end else begin
         pos = -1;
      end
   endtask

   task automatic drive(input logic s, input longint d, input logic iv, input int ic,
                        input longint v, input logic r);
      @(negedge clk);
      check_state();
      step      = s;
      decay     = W'(d);
      inj_valid = iv;
      inj_ch    = CW'(ic);
      inj_val   = W'(v);
      rst       = r;
      model_edge(s, W'(d), iv, CW'(ic), W'(v), r);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic inj(input int ch, input longint v);
      drive(1'b0, 0, 1'b1, ch, v, 1'b0);
   endtask

   task automatic stp(input longint d);
      drive(1'b1, d, 1'b0, 0, 0, 1'b0);
   endtask

   // Scoreboard: every done pulse must match the oldest predicted sweep result.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: got done=1 expected no sweep completion (t=%0t)", $time);
         end else begin
            e = sbq.pop_front();
            if (curr_out !== e.vec || edge_cnt != e.edge_no) begin
               errors++;
               $display("FAIL sweep_result: got %h at edge %0d expected %h at edge %0d",
                        curr_out, edge_cnt, e.vec, e.edge_no);
            end
         end
      end
   end

   // Narrower bank where channel index 3 does not exist.
   initial begin
      rst3 = 1'b1; step3 = 1'b0; decay3 = '0; iv3 = 1'b0; ic3 = '0; ivl3 = '0;
      repeat (2) @(negedge clk);
      rst3 = 1'b0; iv3 = 1'b1; ic3 = 2'd0; ivl3 = W'(100);
      @(negedge clk);
      ic3 = 2'd2; ivl3 = W'(200);
      @(negedge clk);
      ic3 = 2'd3; ivl3 = W'(500);
      @(negedge clk);
      iv3 = 1'b0;
      @(negedge clk);
      check("inv_ch ch0", longint'($signed(curr_out3[0*W +: W])), 100);
      check("inv_ch ch1", longint'($signed(curr_out3[1*W +: W])), 0);
      check("inv_ch ch2", longint'($signed(curr_out3[2*W +: W])), 200);
      u3_finished = 1'b1;
   end

   initial begin
      logic r, s, iv;
      longint d, v;
      int ic;
      rst = 1'b1; step = 1'b0; decay = '0; inj_valid = 1'b0; inj_ch = '0; inj_val = '0;
      for (int k = 0; k < N; k++) m[k] = 0;
      dq = 0; pos = -1; t0 = 0;
      repeat (2) @(negedge clk);

      // basic decay with floor on a negative value
      inj(0, 1000);
      inj(1, -3);
      stp(128);
      idle(7);
      check("basic ch0", chv(0), 500);
      check("basic ch1", chv(1), -2);

      // saturation on accumulate and on multiply
      inj(2, 65000);
      inj(2, 1000);
      idle(1);
      check("sat add ch2", chv(2), 65535);
      stp(512);
      idle(7);
      check("sat mult ch2", chv(2), 65535);
      inj(3, -60000);
      inj(3, -60000);
      idle(1);
      check("sat neg ch3", chv(3), -65536);

      // collision: inject lands on the edge that sweeps ch1
      inj(1, 404);
      idle(1);
      check("pre-collision ch1", chv(1), 400);
      stp(128);
      idle(1);
      inj(1, 10);
      idle(6);
      check("collision ch1", chv(1), 210);

      // second step while busy is dropped
      stp(128);
      idle(1);
      stp(64);
      idle(8);
      check("busy-step ch0", chv(0), 250);
      check("busy-step ch1", chv(1), 105);

      // decay input changes mid-sweep have no effect
      stp(256);
      for (int i = 0; i < 4; i++) drive(1'b0, longint'($urandom_range(0, 1000)), 1'b0, 0, 0, 1'b0);
      idle(4);
      check("decay-toggle ch0", chv(0), 250);
      check("decay-toggle ch1", chv(1), 105);

      // reset in the middle of a sweep
      stp(128);
      idle(1);
      drive(1'b0, 0, 1'b0, 0, 0, 1'b1);
      idle(1);
      check("rst busy", longint'(busy), 0);
      for (int k = 0; k < N; k++) check($sformatf("rst ch%0d", k), chv(k), 0);
      idle(6);
      inj(0, 300);
      stp(128);
      idle(7);
      check("post-rst ch0", chv(0), 150);

      // random traffic
      for (int i = 0; i < 500; i++) begin
         r  = ($urandom_range(0, 149) == 0);
         s  = ($urandom_range(0, 5) == 0);
         d  = $urandom_range(0, 1) ? longint'($urandom_range(0, 1200)) - 600
                                   : longint'($urandom_range(0, 131071)) - 65536;
         iv = $urandom_range(0, 1);
         ic = $urandom_range(0, 3);
         v  = $urandom_range(0, 1) ? longint'($urandom_range(0, 4000)) - 2000
                                   : longint'($urandom_range(0, 131071)) - 65536;
         drive(s, d, iv, ic, v, r);
      end
      idle(10);

      check("pending sweeps", longint'(sbq.size()), 0);
      check("narrow bank ran", longint'(u3_finished), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
